msg_stream_arbiter: RTL and testbench
=====================================

# msg_stream_arbiter

Packet-atomic round-robin arbiter that shares one `msg_parser` AXI-Stream input among `N_SRC` upstream stream sources. It grants one source at a time, forwards that source's whole packet (through its `tlast` beat) via a registered output stage, then rotates priority. Oversized packets are truncated and flagged so the parser is never held by a runaway source. It sits directly in front of `msg_parser` and drives its `s_*` ports.

## Interface

Parameters:

- `N_SRC`, default 2: number of sources, range 2..8.
- `DATA_W`, default 64: tdata width. `KEEP_W = DATA_W/8`.
- `MAX_BEATS`, default 16: maximum beats per packet before forced truncation, at least 2.

Ports (source `i` occupies bit slice `i` of each flattened vector):

- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_tdata` in `N_SRC*DATA_W`: source data.
- `s_tkeep` in `N_SRC*KEEP_W`: source byte enables.
- `s_tlast` in `N_SRC`: source end-of-packet.
- `s_tuser` in `N_SRC`: source error flag.
- `s_tvalid` in `N_SRC`: source valid.
- `s_tready` out `N_SRC`: per-source ready.
- `m_tdata` out `DATA_W`, `m_tkeep` out `KEEP_W`, `m_tlast` out 1, `m_tuser` out 1, `m_tvalid` out 1: registered stream to `msg_parser`.
- `m_tready` in 1: from `msg_parser.s_tready`.
- `m_tid` out `clog2(N_SRC)`: source index of the current `m_*` beat.
- `busy` out 1: high while in GRANT or DROP.
- `drop_cnt` out 16: saturating count of truncated packets.

## Operation

The arbiter has three states.

- **IDLE**
  - Round-robin pick: the first `i` with `s_tvalid[i]=1`, searching from `rr_ptr` upward modulo `N_SRC`.
  - On a hit, register `grant=i`, clear `beat_cnt`, and go to GRANT.
  - All `s_tready` are 0 in this state.
- **GRANT**
  - `s_tready[grant] = !m_tvalid || m_tready`. All other `s_tready` are 0.
  - On accept (`s_tvalid[grant] && s_tready[grant]`), load the output register:
    - `m_tdata`, `m_tkeep` and `m_tuser` from the source; `m_tid=grant`.
    - `m_tlast = s_tlast || (beat_cnt==MAX_BEATS-1)`.
    - `m_tuser` is additionally forced to 1 on a truncating beat.
    - Increment `beat_cnt`.
  - Accepted beat with `s_tlast=1`: go to IDLE and set `rr_ptr=(grant+1) mod N_SRC`.
  - Accepted beat with `beat_cnt==MAX_BEATS-1` and `s_tlast=0` (truncation): `drop_cnt` +1, saturating at 0xFFFF; go to DROP.
  - If the truncating beat itself carries `s_tlast`, the packet is not truncated; it is treated as a normal end of packet.
- **DROP**
  - `s_tready[grant]=1` unconditionally; accepted beats are discarded and do not touch the `m_*` outputs.
  - On an accepted beat with `s_tlast=1`: go to IDLE and advance `rr_ptr` as above.
- **Output register**
  - `m_tvalid` clears when `m_tready && m_tvalid` and no new beat loads in the same cycle.
  - While `m_tvalid && !m_tready`, all `m_*` outputs hold stable.
- **Other rules**
  - `s_tvalid` deasserting mid-packet in GRANT is a bubble: the arbiter stays granted and does not rotate.
  - `s_tkeep` is passed through unchecked.

## Timing

- Reset (asynchronous assert, release on the clock):
  - State IDLE, `rr_ptr=0`, `grant=0`, `beat_cnt=0`.
  - `m_tvalid`, `m_tlast`, `m_tuser`, `m_tdata`, `m_tkeep`, `m_tid` all 0.
  - `s_tready=0`, `busy=0`, `drop_cnt=0`.
  - A reset mid-packet drops the in-flight beat immediately: `m_tvalid` falls asynchronously.
- Arbitration: `s_tvalid` sampled at edge t sets the grant at edge t. `s_tready` is high during cycle t+1. The first beat is accepted at edge t+1, and `m_tvalid` is high from edge t+1. Latency from source accept to `m_*` is 1 cycle.
- After the `tlast` accept at edge t, the state is IDLE for cycle t+1. The next grant happens at edge t+1 and its first accept at edge t+2. This gives a one-cycle gap between packets, which holds even for the same source.
- Throughput is 1 beat/cycle inside a packet while `m_tready=1`.
- `s_tready[grant]` depends combinationally on `m_tready`. There is no combinational path from `s_tvalid` to `s_tready`.
- `busy` is registered and equals (state != IDLE).

## Test plan

1. **Single source.** Source 0 only sends 3-beat packets A and B with `m_tready=1`. Required: 6 output beats with `m_tid=0`, `m_tlast` on beats 3 and 6, a one-cycle gap between the packets, and `drop_cnt=0`.
2. **Round robin.** `N_SRC=2`, both sources continuously valid with 2-beat packets. Required: `m_tid` packet order 0,1,0,1 and no interleaving of beats within a packet.
3. **Backpressure.** Drop `m_tready` for 5 cycles after beat 2 of a 4-beat packet. Required: `m_*` held constant, `s_tready[grant]=0` while `m_tvalid` is high and `m_tready` is low, and exactly 4 output beats in order with no duplicates.
4. **Truncation.** `MAX_BEATS=16`; source 1 sends 20 beats, source 0 is waiting. Required:
   - 16 beats out, the 16th with `m_tlast=1` and `m_tuser=1`.
   - Beats 17..20 accepted and discarded.
   - `drop_cnt=1`, then source 0 is granted next.
   - Exactly 16 beats also passes with no truncation and `drop_cnt` unchanged.
5. **Error and bubbles.** A 3-beat packet with `s_tuser=1` on beat 2 and a 2-cycle `s_tvalid` bubble. Required: `m_tuser=1` only on beat 2, and no rotation during the bubble.
6. **Reset mid-packet.** Assert `rst` during beat 2 of 4. Required: immediate `m_tvalid=0`, `s_tready=0`, `busy=0`. After release, the next grant comes from `rr_ptr=0`.

Source files
------------

// File: rtl/msg_stream_arbiter.sv
// Packet-atomic round-robin arbiter: one granted source streams a whole packet through a
// registered output stage; oversize packets are cut at MAX_BEATS and their tail drained.
`timescale 1ns / 1ps

module msg_stream_arbiter #(
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned KEEP_W   = DATA_W / 8,
  localparam int unsigned ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int unsigned CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC*DATA_W-1:0]  s_tdata,
  input  logic [N_SRC*KEEP_W-1:0]  s_tkeep,
  input  logic [N_SRC-1:0]         s_tlast,
  input  logic [N_SRC-1:0]         s_tuser,
  input  logic [N_SRC-1:0]         s_tvalid,
  output logic [N_SRC-1:0]         s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [ID_W-1:0]          m_tid,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StDrop} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               busy_q;

  logic [DATA_W-1:0]  m_tdata_q;
  logic [KEEP_W-1:0]  m_tkeep_q;
  logic               m_tlast_q, m_tuser_q, m_tvalid_q;
  logic [ID_W-1:0]    m_tid_q;

  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               sel_last, sel_user, sel_valid;
  logic               src_rdy, accept, m_load, at_max;
  logic               pick_hit;
  logic [ID_W-1:0]    pick_idx, next_ptr;
  int unsigned        pick_pos;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
        sel_last  = s_tlast[i];
        sel_user  = s_tuser[i];
        sel_valid = s_tvalid[i];
      end
    end
  end

  // First valid source at or after rr_ptr, wrapping.
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    pick_pos = 0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      pick_pos = (int'(rr_ptr_q) + k) % N_SRC;
      if (!pick_hit && s_tvalid[pick_pos]) begin
        pick_hit = 1'b1;
        pick_idx = ID_W'(pick_pos);
      end
    end
  end

  always_comb begin
    src_rdy = 1'b0;
    case (state_q)
      StGrant: src_rdy = !m_tvalid_q || m_tready;
      StDrop:  src_rdy = 1'b1;
      default: src_rdy = 1'b0;
    endcase
    for (int i = 0; i < int'(N_SRC); i++) begin
      s_tready[i] = src_rdy && (grant_q == ID_W'(i));
    end
  end

  assign accept   = sel_valid && src_rdy;
  assign at_max   = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign next_ptr = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    m_load     = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_hit) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          m_load     = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (sel_last) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end else if (at_max) begin
            state_d = StDrop;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      StDrop: begin
        if (accept && sel_last) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  // A truncating beat closes the packet downstream and is marked as errored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tid_q    <= '0;
    end else if (m_load) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= sel_data;
      m_tkeep_q  <= sel_keep;
      m_tlast_q  <= sel_last || at_max;
      m_tuser_q  <= sel_user || (at_max && !sel_last);
      m_tid_q    <= grant_q;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;
  assign m_tid    = m_tid_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter (N_SRC=2, DATA_W=64, MAX_BEATS=16).
`timescale 1ns / 1ps

module tb_msg_stream_arbiter;

  localparam int N = 2;

  typedef struct packed {
    logic [7:0]  keep;
    logic        tid;
    logic        last;
    logic        user;
    logic [63:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [1:0]   s_tlast, s_tuser, s_tvalid, s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tlast, m_tuser, m_tvalid, m_tid, busy;
  logic         m_tready = 1'b1;
  logic [15:0]  drop_cnt;

  logic [63:0] sd [N];
  logic [7:0]  sk [N];
  logic        sl [N];
  logic        su [N];
  logic        sv [N];

  assign s_tdata  = {sd[1], sd[0]};
  assign s_tkeep  = {sk[1], sk[0]};
  assign s_tlast  = {sl[1], sl[0]};
  assign s_tuser  = {su[1], su[0]};
  assign s_tvalid = {sv[1], sv[0]};

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  beat_t q[$];
  int    cq[$];

  msg_stream_arbiter #(.N_SRC(2), .DATA_W(64), .MAX_BEATS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tid    (m_tid),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      q.push_back('{keep: m_tkeep, tid: m_tid, last: m_tlast, user: m_tuser, data: m_tdata});
      cq.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] dv(input int s, input int p, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(s) << 16) | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int i, input int s, input int p, input int b,
                          input logic last, input logic user);
    beat_t e;
    e = (i < q.size()) ? q[i] : '0;
    chk({tag, "_data"}, e.data, dv(s, p, b));
    chk({tag, "_tid"}, 64'(e.tid), 64'(s));
    chk({tag, "_last"}, 64'(e.last), 64'(last));
    chk({tag, "_user"}, 64'(e.user), 64'(user));
  endtask

  // Drives one packet on source s; gap_len idle cycles precede beat gap_at.
  task automatic send(input int s, input int p, input int n, input int ub, input int gap_at,
                      input int gap_len);
    int w;
    for (int b = 1; b <= n; b++) begin
      if (b == gap_at) begin
        sv[s] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      sv[s] = 1'b1;
      sd[s] = dv(s, p, b);
      sk[s] = {4'(p), 4'(b)};
      sl[s] = (b == n);
      su[s] = (b == ub);
      w = 0;
      @(negedge clk);
      while (!s_tready[s] && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("accept_wait", 64'(w < 300), 64'd1);
      if (w >= 300) begin
        sv[s] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    sv[s] = 1'b0;
    sl[s] = 1'b0;
    su[s] = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      sd[i] = '0; sk[i] = '0; sl[i] = 1'b0; su[i] = 1'b0; sv[i] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tid", 64'(m_tid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single source: two 3-beat packets back to back
    send(0, 1, 3, 0, 0, 0);
    send(0, 2, 3, 0, 0, 0);
    drain();
    chk("t1_count", 64'(q.size()), 64'd6);
    for (int b = 1; b <= 3; b++) chk_beat("t1_a", b - 1, 0, 1, b, b == 3, 1'b0);
    for (int b = 1; b <= 3; b++) chk_beat("t1_b", b + 2, 0, 2, b, b == 3, 1'b0);
    chk("t1_keep", 64'(q[1].keep), 64'h12);
    chk("t1_stream", 64'(cq[1] - cq[0]), 64'd1);
    chk("t1_gap", 64'(cq[3] - cq[2]), 64'd2);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    q.delete(); cq.delete();

    // Round robin: source 0 first, then both continuously valid
    fork
      begin send(0, 3, 2, 0, 0, 0); send(0, 4, 2, 0, 0, 0); end
      begin @(posedge clk); #1; send(1, 3, 2, 0, 0, 0); send(1, 4, 2, 0, 0, 0); end
    join
    drain();
    chk("t2_count", 64'(q.size()), 64'd8);
    chk_beat("t2_p0", 0, 0, 3, 1, 1'b0, 1'b0);
    chk_beat("t2_p0", 1, 0, 3, 2, 1'b1, 1'b0);
    chk_beat("t2_p1", 2, 1, 3, 1, 1'b0, 1'b0);
    chk_beat("t2_p1", 3, 1, 3, 2, 1'b1, 1'b0);
    chk_beat("t2_p2", 4, 0, 4, 1, 1'b0, 1'b0);
    chk_beat("t2_p2", 5, 0, 4, 2, 1'b1, 1'b0);
    chk_beat("t2_p3", 6, 1, 4, 1, 1'b0, 1'b0);
    chk_beat("t2_p3", 7, 1, 4, 2, 1'b1, 1'b0);
    q.delete(); cq.delete();

    // Backpressure: m_tready low for 5 cycles while beat 2 is presented
    fork
      send(0, 5, 4, 0, 0, 0);
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (q.size() < 1 && n < 100);
        m_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_valid", 64'(m_tvalid), 64'd1);
          chk("t3_hold_data", m_tdata, dv(0, 5, 2));
          chk("t3_hold_last", 64'(m_tlast), 64'd0);
          chk("t3_hold_ready", 64'(s_tready), 64'd0);
          chk("t3_busy", 64'(busy), 64'd1);
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    drain();
    chk("t3_count", 64'(q.size()), 64'd4);
    for (int b = 1; b <= 4; b++) chk_beat("t3", b - 1, 0, 5, b, b == 4, 1'b0);
    q.delete(); cq.delete();

    // Truncation: source 1 sends 20 beats while source 0 waits
    fork
      send(1, 6, 20, 0, 0, 0);
      send(0, 7, 2, 0, 0, 0);
    join
    drain();
    chk("t4_count", 64'(q.size()), 64'd18);
    for (int b = 1; b <= 16; b++) chk_beat("t4_trunc", b - 1, 1, 6, b, b == 16, b == 16);
    chk_beat("t4_next", 16, 0, 7, 1, 1'b0, 1'b0);
    chk_beat("t4_next", 17, 0, 7, 2, 1'b1, 1'b0);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    q.delete(); cq.delete();

    // Exactly MAX_BEATS: no truncation
    send(1, 8, 16, 0, 0, 0);
    drain();
    chk("t4b_count", 64'(q.size()), 64'd16);
    chk_beat("t4b_b15", 14, 1, 8, 15, 1'b0, 1'b0);
    chk_beat("t4b_b16", 15, 1, 8, 16, 1'b1, 1'b0);
    chk("t4b_drop_cnt", 64'(drop_cnt), 64'd1);
    q.delete(); cq.delete();

    // Error flag on beat 2, 2-cycle bubble before beat 3, source 1 waiting
    fork
      send(0, 9, 3, 2, 3, 2);
      begin repeat (2) @(posedge clk); #1; send(1, 10, 1, 0, 0, 0); end
    join
    drain();
    chk("t5_count", 64'(q.size()), 64'd4);
    chk_beat("t5", 0, 0, 9, 1, 1'b0, 1'b0);
    chk_beat("t5", 1, 0, 9, 2, 1'b0, 1'b1);
    chk_beat("t5", 2, 0, 9, 3, 1'b1, 1'b0);
    chk_beat("t5_src1", 3, 1, 10, 1, 1'b1, 1'b0);
    q.delete(); cq.delete();

    // Reset mid-packet: rr_ptr is 1 beforehand, so a surviving pointer would pick source 1
    send(0, 11, 1, 0, 0, 0);
    drain();
    q.delete(); cq.delete();
    sv[1] = 1'b1; sd[1] = dv(1, 12, 1); sk[1] = 8'hFF; sl[1] = 1'b0; su[1] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
    sd[1] = dv(1, 12, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_ready", 64'(s_tready), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sv[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); cq.delete();
    fork
      send(0, 13, 1, 0, 0, 0);
      send(1, 14, 1, 0, 0, 0);
    join
    drain();
    chk("t6_count", 64'(q.size()), 64'd2);
    chk_beat("t6_first", 0, 0, 13, 1, 1'b1, 1'b0);
    chk_beat("t6_second", 1, 1, 14, 1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
